// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
//   fetch_state_e : fetch sequencer states
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   FETCH_XLEN    : address/instruction width used by fetch_entry_t
//   PC_INC        : sequential PC increment (bytes)
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned PC_INC     = 4;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// 2-entry synchronous FIFO of fetch results feeding IF/ID.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full unless a pop frees a slot)
//   push_data   : entry to write
//   pop         : remove head (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   count       : number of valid entries (0..2)
//   head_valid  : count != 0
//   head        : oldest entry (storage is reset to zero)
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding req/gnt/rvalid fetches,
// buffers results in a 2-entry FIFO toward IF/ID and discards wrong-path responses after a
// redirect from EX.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   redirect_i/redirect_pc_i: EX redirect and target (low two bits ignored)
//   imem_req_o/imem_addr_o  : fetch request and address (= PC)
//   imem_gnt_i              : request accepted
//   imem_rvalid_i/rdata_i   : response, one per granted request
//   if_valid_o/pc_o/instr_o : FIFO head toward IF/ID
//   if_ready_i              : IF/ID accepts head
//   fetch_pc_o              : current PC register
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = FETCH_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] fetch_pc_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            kill_q, kill_d;

    logic            redirect_ok;
    logic [XLEN-1:0] redirect_tgt;
    logic [1:0]      fifo_count;
    logic            fifo_push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Redirects are not honoured in the boot cycle.
    assign redirect_ok  = redirect_i && (state_q != BOOT);
    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);

    // Request only from REQ with FIFO space; the count cannot grow in REQ, so once raised the
    // request holds until granted.
    assign imem_req_o  = (state_q == REQ) && (fifo_count != 2'd2);
    assign imem_addr_o = pc_q;
    assign fetch_pc_o  = pc_q;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        pend_pc_d = pend_pc_q;
        kill_d    = kill_q;
        fifo_push = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                end
                if (redirect_ok) begin
                    // A raised request must keep its address, so defer the target.
                    if (imem_req_o) begin
                        kill_d    = 1'b1;
                        pend_pc_d = redirect_tgt;
                    end else begin
                        pc_d = redirect_tgt;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (redirect_ok) begin
                        pc_d = redirect_tgt;
                    end else if (kill_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        fifo_push = 1'b1;
                        pc_d      = req_pc_q + XLEN'(PC_INC);
                    end
                end else if (redirect_ok) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redirect_tgt;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC[XLEN-1:0];
            req_pc_q  <= '0;
            pend_pc_q <= '0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
        end
    end

    // Redirect flushes the FIFO; flush priority inside the FIFO drops a same-cycle pop.
    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (if_ready_i),
        .flush     (redirect_ok),
        .count     (fifo_count),
        .head_valid(if_valid_o),
        .head      (head)
    );

    assign if_pc_o    = head.pc;
    assign if_instr_o = head.instr;

endmodule
